steer_ld_qual: RTL

- Producer side of the steering-enable qualification interface.
- Samples left/right load-cell readings from the A2D interface and computes sum and |difference|.
- Generates the hysteresis-qualified rider flags and the 1.3 s settle timer consumed by the steering-enable state machine.
- Honours that state machine's clr_tmr, and forces a safe "rider off" indication when load samples go stale.

---
 rtl/steer_pkg.sv | 27 ++
 rtl/sat_tmr.sv | 38 +++
 rtl/steer_ld_qual.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/steer_pkg.sv
// steer_pkg: widths, default thresholds and the flag bundle shared by the
// load qualification block and its helpers.
// Default rider weight and band values are in load-sum units.
package steer_pkg;

  localparam int LD_W    = 12;
  localparam int SUM_W   = 13;
  localparam int TMR_W   = 26;
  localparam int STALE_W = 20;

  localparam logic [LD_W-1:0]    MIN_RIDER_WEIGHT_DEF = 12'h200;
  localparam logic [LD_W-1:0]    HYSTERESIS_DEF       = 12'h040;
  localparam logic [TMR_W-1:0]   TMR_FULL_CNT_DEF     = 26'd65_000_000;
  localparam logic [STALE_W-1:0] STALE_CYC_DEF        = 20'd1_000_000;
  localparam logic [2:0]         DB_SAMPLES_DEF       = 3'd4;

  typedef struct packed {
    logic gt_min;
    logic lt_min;
    logic gt_1_4;
    logic gt_15_16;
  } ld_flags_t;

  // "Rider off" indication used at reset and whenever samples are stale.
  localparam ld_flags_t FLAGS_SAFE = '{gt_min: 1'b0, lt_min: 1'b1, gt_1_4: 1'b0, gt_15_16: 1'b0};

endpackage

// File: rtl/sat_tmr.sv
// sat_tmr: saturating up-counter with synchronous clear; full flags count==FULL.
// Latency: full is a decode of the registered count, valid the cycle after the edge.
// Backpressure: none; clr has priority over counting.
module sat_tmr #(
  parameter int         W    = 8,
  parameter logic [W-1:0] FULL = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic full
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and park at FULL.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != FULL) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full = (cnt_q == FULL);

endmodule

// File: rtl/steer_ld_qual.sv
// steer_ld_qual: qualifies left/right load-cell samples into rider flags, runs the settle timer and stale watchdog.
// Latency: capture on the ld_vld edge, flags register on the next edge; fully pipelined for back-to-back samples.
// Backpressure: none; LD_DEBOUNCE_EN adds a consecutive-sample debounce on sum_gt_min.
module steer_ld_qual
  import steer_pkg::*;
#(
  parameter logic [LD_W-1:0]    MIN_RIDER_WEIGHT = MIN_RIDER_WEIGHT_DEF,
  parameter logic [LD_W-1:0]    HYSTERESIS       = HYSTERESIS_DEF,
  parameter logic [TMR_W-1:0]   TMR_FULL_CNT     = TMR_FULL_CNT_DEF,
  parameter logic [STALE_W-1:0] STALE_CYC        = STALE_CYC_DEF
`ifdef LD_DEBOUNCE_EN
  ,
  parameter logic [2:0]         DB_SAMPLES       = DB_SAMPLES_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  input  logic            clr_tmr,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16,
  output logic            tmr_full,
  output logic            ld_stale
);

  // Hysteresis band edges, zero-extended so the sum compare is 13-bit unsigned.
  localparam logic [SUM_W-1:0] UPPER_THR = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [SUM_W-1:0] LOWER_THR = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  logic            s1_vld_q;
  logic [LD_W-1:0] lft_q;
  logic [LD_W-1:0] rght_q;
  logic            seen_q;
  logic            stale_full;

  logic [SUM_W-1:0] sum;
  logic [LD_W-1:0]  diff;
  logic [SUM_W-1:0] thr_1_4;
  logic [SUM_W-1:0] thr_15_16;
  logic             sum_hi;
  logic             gt_min_pass;

  ld_flags_t new_flags;
  ld_flags_t flags_d;
  ld_flags_t flags_q;
  ld_flags_t out_flags;

  // Stage 1: capture the sample pair on the strobe and remember that a sample is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      lft_q    <= '0;
      rght_q   <= '0;
    end else begin
      s1_vld_q <= ld_vld;
      if (ld_vld) begin
        lft_q  <= lft_ld;
        rght_q <= rght_ld;
      end
    end
  end

  // Samples count as stale from reset until the first strobe arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
    end else if (ld_vld) begin
      seen_q <= 1'b1;
    end
  end

  assign ld_stale = stale_full | ~seen_q;

  // Stage 2 arithmetic on the captured pair.
  assign sum       = {1'b0, lft_q} + {1'b0, rght_q};
  assign diff      = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
  assign thr_1_4   = sum >> 2;
  assign thr_15_16 = sum - (sum >> 4);
  assign sum_hi    = (sum > UPPER_THR);

`ifdef LD_DEBOUNCE_EN
  logic [2:0] db_cnt_q;
  logic [2:0] db_cnt_d;

  // Run length of consecutive over-threshold samples; broken by a miss or by stale samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (s1_vld_q) begin
      if (!sum_hi) begin
        db_cnt_d = '0;
      end else if (db_cnt_q != DB_SAMPLES) begin
        db_cnt_d = db_cnt_q + 3'd1;
      end
    end else if (ld_stale) begin
      db_cnt_d = '0;
    end
  end

  // Debounce count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end

  assign gt_min_pass = (db_cnt_d == DB_SAMPLES);
`else
  assign gt_min_pass = sum_hi;
`endif

  // Flag values produced by the sample currently in stage 2.
  always_comb begin
    new_flags          = FLAGS_SAFE;
    new_flags.gt_min   = gt_min_pass;
    new_flags.lt_min   = (sum < LOWER_THR);
    new_flags.gt_1_4   = ({1'b0, diff} > thr_1_4);
    new_flags.gt_15_16 = ({1'b0, diff} > thr_15_16);
  end

  // Take a fresh sample's flags; while stale, park on the safe values so they survive
  // until the next sample reaches stage 2.
  always_comb begin
    flags_d = flags_q;
    if (s1_vld_q) begin
      flags_d = new_flags;
    end else if (ld_stale) begin
      flags_d = FLAGS_SAFE;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_SAFE;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out_flags     = ld_stale ? FLAGS_SAFE : flags_q;
  assign sum_gt_min    = out_flags.gt_min;
  assign sum_lt_min    = out_flags.lt_min;
  assign diff_gt_1_4   = out_flags.gt_1_4;
  assign diff_gt_15_16 = out_flags.gt_15_16;

  sat_tmr #(
    .W    (TMR_W),
    .FULL (TMR_FULL_CNT)
  ) u_settle_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_tmr),
    .full  (tmr_full)
  );

  sat_tmr #(
    .W    (STALE_W),
    .FULL (STALE_CYC)
  ) u_stale_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ld_vld),
    .full  (stale_full)
  );

endmodule
